lvds_link_scheduler: RTL and testbench
======================================

Name: lvds_link_scheduler

Overview:
- Round-robin scheduler that shares one LVDS serializer/deserializer lane among NUM_REQ requesters.
- Accepts one word per frame. Launches the frame with a one-cycle frame pulse plus the parallel word toward the serializer.
- Waits for the deserializer's rx frame pulse and returns the received word, tagged with requester id and error status.
- Enforces a timeout and an inter-frame gap. Sits between the requesters and the serializer/deserializer pair, all in the clk_serial domain.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- PARALLEL_WIDTH, 8, frame word width; must match the deserializer.
- GAP_CYCLES, 2, idle cycles forced after each frame completes; 0 is legal.
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before the frame is declared lost; must be > PARALLEL_WIDTH+1.
- CNT_WIDTH, 8, width of the saturating timeout counter.

Ports:
- clk_serial  in  1  serial-rate clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*PARALLEL_WIDTH  packed words; requester i occupies bits [i*W +: W].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- ser_frame_pulse  out  1  one-cycle start-of-frame to the serializer/deserializer.
- ser_word  out  PARALLEL_WIDTH  word to serialize; held stable from LAUNCH until the end of WAIT.
- rx_frame_pulse  in  1  deserializer word-complete strobe.
- rx_word  in  PARALLEL_WIDTH  deserialized word; valid only with rx_frame_pulse.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(NUM_REQ)  requester that owned the completed frame.
- rsp_data  out  PARALLEL_WIDTH  received word; 0 on timeout.
- rsp_error  out  1  frame error flag, qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- timeout_count  out  CNT_WIDTH  saturating count of timed-out frames.

Behaviour:
- Reset values: all registered outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[grant] is combinational, high only in IDLE, same cycle as the grant.
  - On the grant: capture the word into ser_word and the id; pointer <= (grant+1) mod NUM_REQ; next state LAUNCH.
  - No valid requesters: stay in IDLE, req_ready all 0.
- LAUNCH (exactly 1 cycle):
  - ser_frame_pulse=1; clear the wait counter; next state WAIT.
- WAIT:
  - The wait counter increments every cycle.
  - On rx_frame_pulse: rsp_valid=1 next cycle, rsp_data=rx_word, rsp_id=captured id, rsp_error per the optional feature; next state GAP.
  - On counter reaching TIMEOUT_CYCLES with no pulse: rsp_valid=1, rsp_data=0, rsp_error=1; timeout_count increments, saturating at all-ones; next state GAP.
  - rx_frame_pulse in the same cycle the counter hits the limit: treat as success, not timeout.
- GAP:
  - Stay GAP_CYCLES cycles, then go to IDLE.
  - GAP_CYCLES=0: go from WAIT straight to IDLE.
- Nominal latency: accept at cycle T; ser_frame_pulse at T+1; the deserializer returns its pulse at T+1+PARALLEL_WIDTH+1; rsp_valid one cycle after that.
- Pending requests outside IDLE: req_ready stays 0; requesters must hold req_valid and req_data until accepted.
- rx_frame_pulse outside WAIT: ignored; no response, no state change.
- busy is 1 in LAUNCH, WAIT and GAP.
- reset_n asserted mid-frame: immediate return to reset values; the in-flight frame is dropped with no response.

Optional Feature:
- Macro: LVDS_SCHED_DATA_CHECK_EN.
- Defined: on a successful frame, rsp_error = (rx_word != ser_word).
- Undefined: rsp_error=1 only on timeout; no comparator is built.

Test Plan:
- Single requester, loopback: req 1 sends 8'hA5.
  - req_ready[1] in the accept cycle; ser_frame_pulse one cycle later.
  - rsp_valid with rsp_id=1, rsp_data=8'hA5, rsp_error=0.
  - busy drops GAP_CYCLES=2 cycles after the response.
- All 4 requesters valid continuously, pointer 0:
  - Grant order 0,1,2,3,0.
  - ser_frame_pulse never within 2 cycles of the previous frame's response.
- rx_frame_pulse suppressed:
  - rsp_valid 16 cycles after LAUNCH with rsp_error=1, rsp_data=0, timeout_count=1.
  - Force 300 timeouts: timeout_count saturates at 255.
- LVDS_SCHED_DATA_CHECK_EN defined; the deserializer returns 8'h5A for sent 8'hA5 -> rsp_error=1.
  - Same stimulus with the macro undefined -> rsp_error=0.
- Spurious rx_frame_pulse during IDLE and GAP -> no rsp_valid, no state change.
  - rx_frame_pulse coincident with timeout -> success response, timeout_count unchanged.
- reset_n pulsed low mid-WAIT:
  - All outputs return to 0 and no response is issued.
  - The next grant goes to requester 0.

Source files
------------

// File: rtl/lvds_link_scheduler.sv
// Round-robin scheduler sharing one LVDS serializer/deserializer lane among NUM_REQ requesters.
// Optional macro LVDS_SCHED_DATA_CHECK_EN: flag received words that differ from the sent word.
module lvds_link_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned PARALLEL_WIDTH = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                              clk_serial,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*PARALLEL_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              ser_frame_pulse,
    output logic [PARALLEL_WIDTH-1:0]         ser_word,
    input  logic                              rx_frame_pulse,
    input  logic [PARALLEL_WIDTH-1:0]         rx_word,
    output logic                              rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [PARALLEL_WIDTH-1:0]         rsp_data,
    output logic                              rsp_error,
    output logic                              busy,
    output logic [CNT_WIDTH-1:0]              timeout_count
);
    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

    state_t                    state_q, state_d;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [PARALLEL_WIDTH-1:0] ser_word_q, ser_word_d;
    logic                      ser_frame_pulse_q, ser_frame_pulse_d;
    logic [WCNT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic [GCNT_W-1:0]         gap_cnt_q, gap_cnt_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
    logic [PARALLEL_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      rsp_error_q, rsp_error_d;
    logic [CNT_WIDTH-1:0]      timeout_count_q, timeout_count_d;

    logic [PARALLEL_WIDTH-1:0] req_word [NUM_REQ];
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
    logic [ID_W:0]             cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*PARALLEL_WIDTH +: PARALLEL_WIDTH];
    end

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_valid && req_valid[cand[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        id_d              = id_q;
        ser_word_d        = ser_word_q;
        ser_frame_pulse_d = 1'b0;
        wait_cnt_d        = wait_cnt_q;
        gap_cnt_d         = gap_cnt_q;
        rsp_valid_d       = 1'b0;
        rsp_id_d          = rsp_id_q;
        rsp_data_d        = rsp_data_q;
        rsp_error_d       = rsp_error_q;
        timeout_count_d   = timeout_count_q;
        req_ready         = '0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    req_ready[grant_id] = 1'b1;
                    ser_word_d          = req_word[grant_id];
                    id_d                = grant_id;
                    ptr_d               = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    ser_frame_pulse_d   = 1'b1;
                    state_d             = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // LAUNCH counts as the first elapsed cycle, so a timeout response
                // lands exactly TIMEOUT_CYCLES after the frame pulse.
                wait_cnt_d = WCNT_W'(1);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (rx_frame_pulse || (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1))) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    if (rx_frame_pulse) begin
                        rsp_data_d = rx_word;
`ifdef LVDS_SCHED_DATA_CHECK_EN
                        rsp_error_d = (rx_word != ser_word_q);
`else
                        rsp_error_d = 1'b0;
`endif
                    end else begin
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                        if (timeout_count_q != '1) begin
                            timeout_count_d = timeout_count_q + 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GCNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_serial or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            ptr_q             <= '0;
            id_q              <= '0;
            ser_word_q        <= '0;
            ser_frame_pulse_q <= 1'b0;
            wait_cnt_q        <= '0;
            gap_cnt_q         <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_id_q          <= '0;
            rsp_data_q        <= '0;
            rsp_error_q       <= 1'b0;
            timeout_count_q   <= '0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            id_q              <= id_d;
            ser_word_q        <= ser_word_d;
            ser_frame_pulse_q <= ser_frame_pulse_d;
            wait_cnt_q        <= wait_cnt_d;
            gap_cnt_q         <= gap_cnt_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_id_q          <= rsp_id_d;
            rsp_data_q        <= rsp_data_d;
            rsp_error_q       <= rsp_error_d;
            timeout_count_q   <= timeout_count_d;
        end
    end

    assign ser_frame_pulse = ser_frame_pulse_q;
    assign ser_word        = ser_word_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = rsp_id_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_error       = rsp_error_q;
    assign busy            = (state_q != S_IDLE);
    assign timeout_count   = timeout_count_q;
endmodule

// File: tb/tb_lvds_link_scheduler.sv
// Directed self-checking bench for lvds_link_scheduler with default parameters.
module tb_lvds_link_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned W       = 8;

`ifdef LVDS_SCHED_DATA_CHECK_EN
    localparam bit DATA_CHECK = 1'b1;
`else
    localparam bit DATA_CHECK = 1'b0;
`endif

    logic                   clk_serial = 1'b0;
    logic                   reset_n    = 1'b0;
    logic [NUM_REQ-1:0]     req_valid  = '0;
    logic [NUM_REQ*W-1:0]   req_data   = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   ser_frame_pulse;
    logic [W-1:0]           ser_word;
    logic                   rx_frame_pulse = 1'b0;
    logic [W-1:0]           rx_word        = '0;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [W-1:0]           rsp_data;
    logic                   rsp_error;
    logic                   busy;
    logic [7:0]             timeout_count;

    int checks = 0;
    int errors = 0;

    lvds_link_scheduler #(
        .NUM_REQ(NUM_REQ), .PARALLEL_WIDTH(W), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)
    ) dut (
        .clk_serial(clk_serial), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ser_frame_pulse(ser_frame_pulse), .ser_word(ser_word),
        .rx_frame_pulse(rx_frame_pulse), .rx_word(rx_word),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .busy(busy), .timeout_count(timeout_count)
    );

    always #5 clk_serial = ~clk_serial;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk_serial);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = '0; req_data = '0; rx_frame_pulse = 1'b0; rx_word = '0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic set_req(input int idx, input logic [W-1:0] data);
        req_valid[idx]        = 1'b1;
        req_data[idx*W +: W]  = data;
    endtask

    task automatic test_reset();
        step(); #1;
        checks++;
        if ({req_ready, ser_frame_pulse, ser_word, rsp_valid, rsp_id, rsp_data, rsp_error, busy, timeout_count} !== '0)
            begin errors++; $display("FAIL reset_outputs got %0h want 0",
                {req_ready, ser_frame_pulse, ser_word, rsp_valid, rsp_id, rsp_data, rsp_error, busy, timeout_count}); end
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 8'hA5); #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b want 0010", req_ready); end
        step(); req_valid = '0; #1;
        checks++; if ({ser_frame_pulse, busy, ser_word} !== {1'b1, 1'b1, 8'hA5})
            begin errors++; $display("FAIL single_launch got pulse=%b busy=%b word=%h want 1 1 a5", ser_frame_pulse, busy, ser_word); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_launch got %b want 0000", req_ready); end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++; if ({ser_frame_pulse, rsp_valid} !== 2'b00)
                begin errors++; $display("FAIL single_wait%0d got pulse=%b rsp=%b want 0 0", k, ser_frame_pulse, rsp_valid); end
        end
        step(); rx_frame_pulse = 1'b1; rx_word = 8'hA5;
        step(); rx_frame_pulse = 1'b0;
        checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_error, busy} !== {1'b1, 2'd1, 8'hA5, 1'b0, 1'b1})
            begin errors++; $display("FAIL single_rsp got v=%b id=%0d d=%h e=%b busy=%b want 1 1 a5 0 1",
                rsp_valid, rsp_id, rsp_data, rsp_error, busy); end
        step();
        checks++; if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL single_gap1 got v=%b busy=%b want 0 1", rsp_valid, busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int waited;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i));
        for (int f = 0; f < 5; f++) begin
            int exp_id = f % 4;
            #1;
            waited = 0;
            while (req_ready === '0 && waited < 10) begin step(); #1; waited++; end
            if (f > 0) begin
                checks++; if (waited != 2) begin errors++; $display("FAIL rr_gap%0d got %0d want 2", f, waited); end
            end
            checks++; if (req_ready !== 4'(1 << exp_id))
                begin errors++; $display("FAIL rr_grant%0d got %b want %b", f, req_ready, 4'(1 << exp_id)); end
            step();
            checks++; if ({ser_frame_pulse, ser_word} !== {1'b1, 8'(8'h10 + exp_id)})
                begin errors++; $display("FAIL rr_launch%0d got pulse=%b word=%h want 1 %h", f, ser_frame_pulse, ser_word, 8'(8'h10 + exp_id)); end
            repeat (8) step();
            step(); rx_frame_pulse = 1'b1; rx_word = 8'(8'h10 + exp_id);
            step(); rx_frame_pulse = 1'b0;
            checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(exp_id), 8'(8'h10 + exp_id)})
                begin errors++; $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h want 1 %0d %h", f, rsp_valid, rsp_id, rsp_data, exp_id, 8'(8'h10 + exp_id)); end
        end
        req_valid = '0;
        repeat (3) step();
    endtask

    task automatic test_timeout();
        int n = 0;
        int cyc = 0;
        do_reset();
        set_req(2, 8'h3C); #1;
        step(); req_valid = '0; #1;
        checks++; if (ser_frame_pulse !== 1'b1) begin errors++; $display("FAIL to_launch got %b want 1", ser_frame_pulse); end
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early%0d got rsp_valid=%b want 0", k, rsp_valid); end
        end
        step();
        checks++; if ({rsp_valid, rsp_error, rsp_data, rsp_id, timeout_count} !== {1'b1, 1'b1, 8'h00, 2'd2, 8'd1})
            begin errors++; $display("FAIL to_rsp got v=%b e=%b d=%h id=%0d cnt=%0d want 1 1 00 2 1",
                rsp_valid, rsp_error, rsp_data, rsp_id, timeout_count); end
        req_valid[0] = 1'b1;
        while (n < 300 && cyc < 300 * 25) begin
            step(); cyc++;
            if (rsp_valid === 1'b1) begin
                n++;
                if (n == 253) begin
                    checks++; if (timeout_count !== 8'd254) begin errors++; $display("FAIL to_cnt254 got %0d want 254", timeout_count); end
                end
            end
        end
        req_valid = '0;
        checks++; if (n != 300) begin errors++; $display("FAIL to_count_frames got %0d want 300", n); end
        checks++; if (timeout_count !== 8'hFF) begin errors++; $display("FAIL to_saturate got %0d want 255", timeout_count); end
        repeat (25) step();
    endtask

    task automatic test_data_check();
        do_reset();
        set_req(0, 8'hA5); #1;
        step(); req_valid = '0;
        repeat (8) step();
        step(); rx_frame_pulse = 1'b1; rx_word = 8'h5A;
        step(); rx_frame_pulse = 1'b0;
        checks++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'h5A, DATA_CHECK})
            begin errors++; $display("FAIL data_check got v=%b d=%h e=%b want 1 5a %b", rsp_valid, rsp_data, rsp_error, DATA_CHECK); end
        repeat (3) step();
    endtask

    task automatic test_spurious();
        do_reset();
        rx_frame_pulse = 1'b1; rx_word = 8'h33;
        step(); rx_frame_pulse = 1'b0;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL spur_idle got v=%b busy=%b want 0 0", rsp_valid, busy); end
        set_req(3, 8'h44); #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL spur_grant got %b want 1000", req_ready); end
        step(); req_valid = '0;
        repeat (8) step();
        step(); rx_frame_pulse = 1'b1; rx_word = 8'h44;
        step(); rx_word = 8'h99;
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 8'h44})
            begin errors++; $display("FAIL spur_rsp got v=%b id=%0d d=%h want 1 3 44", rsp_valid, rsp_id, rsp_data); end
        step(); rx_frame_pulse = 1'b0;
        checks++; if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL spur_gap got v=%b busy=%b want 0 1", rsp_valid, busy); end
        step();
        checks++; if ({busy, rsp_data} !== {1'b0, 8'h44}) begin errors++; $display("FAIL spur_after got busy=%b d=%h want 0 44", busy, rsp_data); end
    endtask

    task automatic test_coincident();
        do_reset();
        set_req(1, 8'h77); #1;
        step(); req_valid = '0;
        repeat (14) step();
        step(); rx_frame_pulse = 1'b1; rx_word = 8'h77;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL coin_early got %b want 0", rsp_valid); end
        step(); rx_frame_pulse = 1'b0;
        checks++; if ({rsp_valid, rsp_error, rsp_data, timeout_count} !== {1'b1, 1'b0, 8'h77, 8'd0})
            begin errors++; $display("FAIL coin_rsp got v=%b e=%b d=%h cnt=%0d want 1 0 77 0", rsp_valid, rsp_error, rsp_data, timeout_count); end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_wait();
        int waited = 0;
        bit saw = 1'b0;
        do_reset();
        set_req(1, 8'hAA);
        step(); req_valid = '0;
        while (!(rsp_valid === 1'b1) && waited < 40) begin step(); waited++; end
        waited = 0;
        while (busy !== 1'b0 && waited < 10) begin step(); waited++; end
        checks++; if ({busy, timeout_count} !== {1'b0, 8'd1}) begin errors++; $display("FAIL rst_pre got busy=%b cnt=%0d want 0 1", busy, timeout_count); end
        set_req(1, 8'hBB); #1;
        step(); req_valid = '0;
        repeat (4) step();
        reset_n = 1'b0; #1;
        checks++;
        if ({req_ready, ser_frame_pulse, ser_word, rsp_valid, rsp_id, rsp_data, rsp_error, busy, timeout_count} !== '0)
            begin errors++; $display("FAIL rst_mid got %0h want 0",
                {req_ready, ser_frame_pulse, ser_word, rsp_valid, rsp_id, rsp_data, rsp_error, busy, timeout_count}); end
        step(); step(); reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rx_frame_pulse = (k == 5); rx_word = 8'hBB;
            step();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        rx_frame_pulse = 1'b0;
        checks++; if (saw) begin errors++; $display("FAIL rst_no_rsp got activity=1 want 0"); end
        req_valid = '1; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr got %b want 0001", req_ready); end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_data_check();
        test_spurious();
        test_coincident();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
